// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, datapath modes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mdu_pkg;

    // Default operand width; HI and LO are each this wide.
    localparam int MDU_WIDTH = 32;

    // E-stage MDU operation codes; 3'b111 is undefined and treated as NOP.
    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110
    } mdu_op_e;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } mdu_state_e;

    // Iteration datapath mode.
    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mdu_mode_e;

    // True for the ops that run the multi-cycle iterative datapath.
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // True for the signed variants, which work on magnitudes plus sign flags.
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    // True for the divide variants.
    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One radix-2 iteration of unsigned shift-add multiply or restoring divide on a 2*WIDTH accumulator.
// Latency: purely combinational; the caller registers the accumulator once per cycle.
// Backpressure: none; the caller decides when to step.
module mdu_iter_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  mdu_mode_e            i_mode,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_opnd,
    output logic [2*WIDTH-1:0]   o_acc
);

    // Multiply: upper half accumulates, lower half holds the remaining multiplier bits.
    logic [WIDTH:0]   w_mul_sum;
    // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH+1:0] w_div_diff;
    logic             w_div_borrow;
    logic [WIDTH-1:0] w_div_rem;

    // Multiply step: conditionally add multiplicand, then shift the whole accumulator right.
    always_comb begin
        w_mul_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]};
        if (i_acc[0]) begin
            w_mul_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_opnd};
        end
    end

    // Divide step: shift in the next dividend bit and trial-subtract the divisor.
    // The shifted remainder needs WIDTH+1 bits; one more bit holds the borrow.
    always_comb begin
        w_div_shift  = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
        w_div_diff   = {1'b0, w_div_shift} - {2'b00, i_opnd};
        w_div_borrow = w_div_diff[WIDTH+1];
        // On borrow, restore; otherwise keep the difference. With a zero divisor the
        // subtraction never borrows, so the quotient saturates to all-ones and the
        // remainder ends up holding the dividend.
        w_div_rem    = w_div_borrow ? w_div_shift[WIDTH-1:0] : w_div_diff[WIDTH-1:0];
    end

    // Select the next accumulator value for the active mode.
    always_comb begin
        o_acc = i_acc;
        if (i_mode == MODE_MUL) begin
            o_acc = {w_mul_sum, i_acc[WIDTH-1:1]};
        end else begin
            o_acc = {w_div_rem, i_acc[WIDTH-2:0], ~w_div_borrow};
        end
    end

endmodule

// File: rtl/mdu_hilo.sv
// E-stage multiply/divide unit with HI/LO registers; MTHI/MTLO take effect at the issuing edge.
// Latency: MULT/MULTU/DIV/DIVU hold MduBusyE high for WIDTH+1 cycles, HI/LO written at the last busy edge.
// Backpressure: MduBusyE stalls the pipeline front end; MduCancel aborts an in-flight op without touching HI/LO.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StartE,
    input  logic [2:0]       MduOpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             MduCancel,
    output logic             MduBusyE,
    output logic [WIDTH-1:0] HiE,
    output logic [WIDTH-1:0] LoE
);

    localparam int ITER = WIDTH;
    localparam int CW   = $clog2(ITER + 1);

    mdu_state_e         r_state;
    mdu_state_e         w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    mdu_mode_e          r_mode;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_idle;
    logic               w_start_md;
    logic               w_launch;
    logic               w_mthi;
    logic               w_mtlo;
    logic               w_last;
    logic               w_is_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign HiE = r_hi;
    assign LoE = r_lo;

    // Issue decode: only IDLE accepts work; DONE ignores StartE because the same
    // instruction is still sitting in E. A cancel suppresses any issue this cycle.
    always_comb begin
        w_idle     = (r_state == ST_IDLE);
        w_start_md = w_idle && StartE && is_muldiv(MduOpE);
        w_launch   = w_start_md && !MduCancel;
        w_mthi     = w_idle && StartE && (MduOpE == OP_MTHI) && !MduCancel;
        w_mtlo     = w_idle && StartE && (MduOpE == OP_MTLO) && !MduCancel;
        w_last     = (r_state == ST_RUN) && (r_cnt == CW'(1)) && !MduCancel;
    end

    // Operand conditioning: signed ops iterate on magnitudes and keep the signs aside.
    // The most negative value maps to itself, which is the correct unsigned magnitude.
    always_comb begin
        w_is_div = is_div_op(MduOpE);
        w_a_neg  = is_signed_op(MduOpE) && SrcAE[WIDTH-1];
        w_b_neg  = is_signed_op(MduOpE) && SrcBE[WIDTH-1];
        w_a_abs  = w_a_neg ? (-SrcAE) : SrcAE;
        w_b_abs  = w_b_neg ? (-SrcBE) : SrcBE;
    end

    mdu_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_mode (r_mode),
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .o_acc  (w_acc_nxt)
    );

    // Sign fix-up of the final iteration's output: product negated as a whole;
    // quotient by the XOR of signs, remainder by the dividend sign.
    always_comb begin
        w_prod   = r_neg_q ? (-w_acc_nxt) : w_acc_nxt;
        w_quo    = w_acc_nxt[WIDTH-1:0];
        w_rem    = w_acc_nxt[2*WIDTH-1:WIDTH];
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (r_mode == MODE_DIV) begin
            w_res_lo = r_neg_q ? (-w_quo) : w_quo;
            w_res_hi = r_neg_r ? (-w_rem) : w_rem;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and stall request. Busy rises combinationally in the issue cycle so
    // the hazard unit freezes F/D before the first edge; cancel wins over completion.
    always_comb begin
        w_state_nxt = r_state;
        MduBusyE    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_md) begin
                    MduBusyE = 1'b1;
                    if (!MduCancel) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                MduBusyE = 1'b1;
                if (MduCancel) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CW'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Iteration state: load operands on launch, then step once per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opnd  <= '0;
            r_mode  <= MODE_MUL;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_launch) begin
            r_cnt   <= CW'(ITER);
            r_mode  <= w_is_div ? MODE_DIV : MODE_MUL;
            r_acc   <= {{WIDTH{1'b0}}, (w_is_div ? w_a_abs : w_b_abs)};
            r_opnd  <= w_is_div ? w_b_abs : w_a_abs;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
        end else if (r_state == ST_RUN) begin
            r_cnt   <= r_cnt - CW'(1);
            r_acc   <= w_acc_nxt;
        end
    end

    // HI/LO: direct moves from IDLE, or the sign-corrected result on the final step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_last) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else begin
            if (w_mthi) begin
                r_hi <= SrcAE;
            end
            if (w_mtlo) begin
                r_lo <= SrcAE;
            end
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed self-checking bench for mdu_hilo with hand-computed HI/LO and busy expectations.
// Latency: inputs driven and outputs sampled just after the falling edge.
// Backpressure: every busy wait is bounded by a cycle budget.
module tb_mdu_hilo;
    import mdu_pkg::*;

    logic        clk;
    logic        rst;
    logic        StartE;
    logic [2:0]  MduOpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        MduCancel;
    logic        MduBusyE;
    logic [31:0] HiE;
    logic [31:0] LoE;

    int n_vec = 0;
    int n_err = 0;
    int n_busy;

    mdu_hilo #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .StartE    (StartE),
        .MduOpE    (MduOpE),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .MduCancel (MduCancel),
        .MduBusyE  (MduBusyE),
        .HiE       (HiE),
        .LoE       (LoE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op and count busy cycles; returns sampled in the cycle busy first reads low.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit hold_start, output int cnt);
        @(negedge clk);
        StartE = 1'b1;
        MduOpE = op;
        SrcAE  = a;
        SrcBE  = b;
        #1;
        cnt = 0;
        while (MduBusyE && cnt < 100) begin
            cnt++;
            @(negedge clk);
            if (!hold_start) StartE = 1'b0;
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; StartE = 1'b0; MduOpE = OP_NOP; SrcAE = '0; SrcBE = '0; MduCancel = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_vec("reset_busy", 64'(MduBusyE), 64'd0);
        check_vec("reset_hi", 64'(HiE), 64'd0);
        check_vec("reset_lo", 64'(LoE), 64'd0);
        rst = 1'b0;

        // MTHI then MTLO back-to-back: never busy, each visible one cycle later.
        @(negedge clk);
        StartE = 1'b1; MduOpE = OP_MTHI; SrcAE = 32'h1234_5678; #1;
        check_vec("mthi_busy", 64'(MduBusyE), 64'd0);
        check_vec("mthi_hi_before", 64'(HiE), 64'd0);
        @(negedge clk);
        #1;
        check_vec("mthi_hi_after", 64'(HiE), 64'h1234_5678);
        MduOpE = OP_MTLO; SrcAE = 32'hCAFE_BABE; #1;
        check_vec("mtlo_busy", 64'(MduBusyE), 64'd0);
        check_vec("mtlo_lo_before", 64'(LoE), 64'd0);
        @(negedge clk);
        StartE = 1'b0; #1;
        check_vec("mtlo_lo_after", 64'(LoE), 64'hCAFE_BABE);
        check_vec("mtlo_hi_kept", 64'(HiE), 64'h1234_5678);

        // NOP and undefined op have no effect.
        @(negedge clk);
        StartE = 1'b1; MduOpE = OP_NOP; SrcAE = 32'h5555_5555; #1;
        check_vec("nop_busy", 64'(MduBusyE), 64'd0);
        @(negedge clk);
        MduOpE = 3'b111; #1;
        check_vec("undef_busy", 64'(MduBusyE), 64'd0);
        @(negedge clk);
        StartE = 1'b0; #1;
        check_vec("nop_hilo", {HiE, LoE}, 64'h1234_5678_CAFE_BABE);

        // DIVU cancelled at RUN cycle 10: busy drops next cycle, HI/LO untouched.
        @(negedge clk);
        StartE = 1'b1; MduOpE = OP_DIVU; SrcAE = 32'd1000; SrcBE = 32'd7; #1;
        check_vec("cancel_start_busy", 64'(MduBusyE), 64'd1);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            StartE = 1'b0;
            if (i == 10) MduCancel = 1'b1;
            #1;
        end
        check_vec("cancel_cycle_busy", 64'(MduBusyE), 64'd1);
        @(negedge clk);
        MduCancel = 1'b0; #1;
        check_vec("cancel_busy_drop", 64'(MduBusyE), 64'd0);
        check_vec("cancel_hilo", {HiE, LoE}, 64'h1234_5678_CAFE_BABE);

        // New MULTU after the cancel completes correctly.
        run_op(OP_MULTU, 32'h0001_0000, 32'h0003_0000, 1'b0, n_busy);
        check_vec("post_cancel_cycles", 64'(n_busy), 64'd33);
        check_vec("post_cancel_hilo", {HiE, LoE}, 64'h0000_0003_0000_0000);

        // Cancel in the start cycle, and MTHI suppressed by a concurrent cancel.
        @(negedge clk);
        StartE = 1'b1; MduOpE = OP_MULT; SrcAE = 32'd9; SrcBE = 32'd9; MduCancel = 1'b1; #1;
        check_vec("cancel0_busy", 64'(MduBusyE), 64'd1);
        @(negedge clk);
        MduOpE = OP_MTHI; SrcAE = 32'hDEAD_BEEF; #1;
        check_vec("cancel0_busy_next", 64'(MduBusyE), 64'd0);
        @(negedge clk);
        StartE = 1'b0; MduCancel = 1'b0; #1;
        check_vec("cancel_mthi_hilo", {HiE, LoE}, 64'h0000_0003_0000_0000);

        // Main arithmetic vectors.
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, n_busy);
        check_vec("multu_cycles", 64'(n_busy), 64'd33);
        check_vec("multu_done_busy", 64'(MduBusyE), 64'd0);
        check_vec("multu_hilo", {HiE, LoE}, 64'hFFFF_FFFE_0000_0001);

        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, n_busy);
        check_vec("mult_cycles", 64'(n_busy), 64'd33);
        check_vec("mult_hilo", {HiE, LoE}, 64'hFFFF_FFFF_FFFF_FFEB);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, n_busy);
        check_vec("div_neg_cycles", 64'(n_busy), 64'd33);
        check_vec("div_neg_hilo", {HiE, LoE}, 64'hFFFF_FFFF_FFFF_FFFD);

        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, n_busy);
        check_vec("div_negb_hilo", {HiE, LoE}, 64'h0000_0001_FFFF_FFFD);

        run_op(OP_DIVU, 32'd100, 32'd0, 1'b0, n_busy);
        check_vec("divu_zero_hilo", {HiE, LoE}, 64'h0000_0064_FFFF_FFFF);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, n_busy);
        check_vec("div_wrap_hilo", {HiE, LoE}, 64'h0000_0000_8000_0000);

        run_op(OP_DIVU, 32'd1000, 32'd7, 1'b0, n_busy);
        check_vec("divu_hilo", {HiE, LoE}, 64'h0000_0006_0000_008E);

        // Reset at RUN cycle 5 clears everything.
        @(negedge clk);
        StartE = 1'b1; MduOpE = OP_MULTU; SrcAE = 32'd15; SrcBE = 32'd15;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            StartE = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; #1;
        check_vec("rst_mid_busy", 64'(MduBusyE), 64'd0);
        check_vec("rst_mid_hilo", {HiE, LoE}, 64'd0);

        // StartE held through DONE with new operands: exactly one op executes.
        run_op(OP_MULTU, 32'd3, 32'd5, 1'b1, n_busy);
        check_vec("hold_cycles", 64'(n_busy), 64'd33);
        check_vec("hold_done_busy", 64'(MduBusyE), 64'd0);
        check_vec("hold_hilo", {HiE, LoE}, 64'd15);
        SrcAE = 32'd4;
        @(negedge clk);
        StartE = 1'b0; #1;
        check_vec("hold_after_busy", 64'(MduBusyE), 64'd0);
        repeat (3) @(negedge clk);
        #1;
        check_vec("hold_hilo_stable", {HiE, LoE}, 64'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
